// File: rtl/data_register.sv
// Data register (DR) of the processor datapath.
// Holds one word loaded from the internal bus, data memory or instruction
// memory, with fixed source priority bus > DM > InsM. The stored word drives
// the bus and the DM write-data port continuously; there is no output enable.
// The output comes straight from the flop, so there is no combinational path
// from any data input to dataout.

module data_register #(
   parameter int unsigned reg_width = 12
) (
   input  logic                 clk,
   input  logic                 reset,           // asynchronous, active-low
   input  logic                 writeEn_frBus,
   input  logic                 writeEn_frDM,
   input  logic                 writeEn_frInsM,
   input  logic [reg_width-1:0] bus_datain,
   input  logic [reg_width-1:0] DM_datain,
   input  logic [reg_width-1:0] InsM_datain,
   output logic [reg_width-1:0] dataout
);

   logic [reg_width-1:0] data_q;
   logic [reg_width-1:0] data_d;

   // Next-state select: fixed priority bus > DM > InsM, otherwise hold.
   // Several enables high together is legal; only the highest one loads.
   always_comb begin
      data_d = data_q;
      if (writeEn_frBus) begin
         data_d = bus_datain;
      end else if (writeEn_frDM) begin
         data_d = DM_datain;
      end else if (writeEn_frInsM) begin
         data_d = InsM_datain;
      end
   end

   // State register: reset clears at once and overrides any pending load.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   // Output is the stored word, always driven.
   assign dataout = data_q;

endmodule

// File: tb/tb_data_register.sv
// Directed bench for data_register: expected words are pushed to a scoreboard
// queue when stimulus is driven and popped/compared just after the loading edge.

module tb_data_register;

   localparam int W = 12;

   logic         clk = 1'b0;
   logic         reset;
   logic         en_bus, en_dm, en_insm;
   logic [W-1:0] bus_d, dm_d, insm_d;
   logic [W-1:0] dataout;

   int total = 0;
   int bad   = 0;

   logic [W-1:0] exp_q[$];
   string        tag_q[$];
   logic [W-1:0] model;

   data_register #(
      .reg_width (W)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .writeEn_frBus  (en_bus),
      .writeEn_frDM   (en_dm),
      .writeEn_frInsM (en_insm),
      .bus_datain     (bus_d),
      .DM_datain      (dm_d),
      .InsM_datain    (insm_d),
      .dataout        (dataout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      total++;
      assert (obs === expv)
      else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Drive enables/data (called at a negedge), push expected, compare after the edge,
   // then return to the next negedge.
   task automatic step(input string tag, input logic b, input logic d, input logic i,
                       input logic [W-1:0] bv, input logic [W-1:0] dv, input logic [W-1:0] iv,
                       input logic [W-1:0] expv);
      logic [W-1:0] e;
      string        t;
      en_bus = b; en_dm = d; en_insm = i;
      bus_d = bv; dm_d = dv; insm_d = iv;
      exp_q.push_back(expv);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check(t, dataout, e);
      @(negedge clk);
   endtask

   initial begin
      // Reset asserted from time 0 with all enables high and data all ones.
      reset = 1'b0;
      en_bus = 1'b1; en_dm = 1'b1; en_insm = 1'b1;
      bus_d = 12'hFFF; dm_d = 12'hFFF; insm_d = 12'hFFF;
      #1;
      check("reset_initial", dataout, 12'h000);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check("reset_hold", dataout, 12'h000);
      end
      @(negedge clk);
      reset = 1'b1;

      // Load a nonzero word, then assert reset mid-cycle: must clear at once.
      step("preload", 1'b1, 1'b0, 1'b0, 12'h5A5, 12'h000, 12'h000, 12'h5A5);
      en_bus = 1'b1; en_dm = 1'b1; en_insm = 1'b1;
      bus_d = 12'hFFF; dm_d = 12'hFFF; insm_d = 12'hFFF;
      #2 reset = 1'b0;
      #1 check("reset_midcycle", dataout, 12'h000);
      for (int k = 0; k < 2; k++) begin
         @(posedge clk);
         #1;
         check("reset_ignores_en", dataout, 12'h000);
      end
      @(negedge clk);
      reset = 1'b1;

      // Single-source loads, back to back.
      step("load_bus", 1'b1, 1'b0, 1'b0, 12'hE08, 12'h803, 12'h800, 12'hE08);
      step("load_dm", 1'b0, 1'b1, 1'b0, 12'h008, 12'hFFB, 12'h800, 12'hFFB);
      step("load_insm", 1'b0, 1'b0, 1'b1, 12'h008, 12'hFFB, 12'h001, 12'h001);

      // No enables: data changes must not reach dataout, combinationally or on edges.
      bus_d = 12'hFFE; dm_d = 12'h004; insm_d = 12'hFFE;
      en_bus = 1'b0; en_dm = 1'b0; en_insm = 1'b0;
      #1 check("no_comb_path", dataout, 12'h001);
      @(negedge clk);
      step("hold_1", 1'b0, 1'b0, 1'b0, 12'hFFE, 12'hFFE, 12'hFFE, 12'h001);
      step("hold_2", 1'b0, 1'b0, 1'b0, 12'h001, 12'h000, 12'h7FF, 12'h001);

      // Priority.
      step("prio_all", 1'b1, 1'b1, 1'b1, 12'hA5A, 12'h3C3, 12'h111, 12'hA5A);
      step("prio_dm_insm", 1'b0, 1'b1, 1'b1, 12'hA5A, 12'h3C3, 12'h111, 12'h3C3);
      step("prio_bus_insm", 1'b1, 1'b0, 1'b1, 12'h6B2, 12'h3C3, 12'h111, 12'h6B2);
      step("prio_bus_dm", 1'b1, 1'b1, 1'b0, 12'h800, 12'h3C3, 12'h111, 12'h800);
      step("prio_dm_insm2", 1'b0, 1'b1, 1'b1, 12'hA5A, 12'h3C3, 12'h111, 12'h3C3);

      // Reset pulse between edges with a pending bus load.
      en_bus = 1'b1; en_dm = 1'b0; en_insm = 1'b0;
      bus_d = 12'h777;
      #2 reset = 1'b0;
      #1 check("reset_pulse", dataout, 12'h000);
      #1 reset = 1'b1;
      #1 check("reset_pulse_hold", dataout, 12'h000);
      @(posedge clk);
      #1 check("post_reset_load", dataout, 12'h777);
      @(negedge clk);

      // Random loads against a small priority model.
      model = 12'h777;
      for (int k = 0; k < 16; k++) begin
         logic         b, d, i;
         logic [W-1:0] bv, dv, iv;
         b  = 1'($urandom_range(0, 1));
         d  = 1'($urandom_range(0, 1));
         i  = 1'($urandom_range(0, 1));
         bv = W'($urandom);
         dv = W'($urandom);
         iv = W'($urandom);
         if (b)      model = bv;
         else if (d) model = dv;
         else if (i) model = iv;
         step("random", b, d, i, bv, dv, iv, model);
      end

      total++;
      assert (exp_q.size() == 0)
      else begin
         bad++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
